flip_arbiter: RTL

FLIP_ARBITER -- requirements
Module: flip_arbiter

---
 rtl/flip_arbiter_if.sv | 43 ++++
 rtl/flip_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/flip_arbiter_if.sv
// rtl/flip_arbiter_if.sv - requester, response and flip-controller bundle for flip_arbiter
interface flip_arbiter_if;
  // Requester command channels
  logic        req0_valid;
  logic [15:0] req0_cmd;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_cmd;
  logic        req1_ready;

  // Shared response channel
  logic        resp0_valid;
  logic        resp1_valid;
  logic [15:0] resp_data;
  logic        resp_err;

  // Flip controller side
  logic        fc_start;
  logic [7:0]  fc_base_addr;
  logic [1:0]  fc_r1;
  logic [1:0]  fc_r2;
  logic [1:0]  fc_c1;
  logic [1:0]  fc_c2;
  logic        fc_done;
  logic [15:0] fc_flipped_out;

  // Status
  logic        busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, fc_done, fc_flipped_out,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
    output fc_start, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2, busy
  );

  // Requesters and flip controller side
  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, fc_done, fc_flipped_out,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
    input  fc_start, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2, busy
  );
endinterface

// File: rtl/flip_arbiter.sv
// rtl/flip_arbiter.sv - two-requester round-robin arbiter in front of one flip controller
// Optional feature macro: FLIP_ARB_TIMEOUT_EN (WAIT-state timeout with error response)
module flip_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  flip_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rr_ptr;
  logic        grant;
  logic        accept;
  logic [15:0] sel_cmd;
  logic        req_id;
  logic [7:0]  base_q;
  logic [1:0]  r1_q;
  logic [1:0]  r2_q;
  logic [1:0]  c1_q;
  logic [1:0]  c2_q;
  logic [15:0] data_q;
  logic        done_hit;
  logic        timeout_hit;
  logic        resp0;
  logic        resp1;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("flip_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  // Offer the IDLE slot to the sole valid requester, otherwise to the round-robin pointer.
  always_comb begin
    grant = rr_ptr;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant = 1'b1;
    end
  end

  assign accept   = !rst && (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
  assign sel_cmd  = grant ? bus.req1_cmd : bus.req0_cmd;
  // Completion is only meaningful while a command is outstanding.
  assign done_hit = (state == WAIT) && bus.fc_done;

`ifdef FLIP_ARB_TIMEOUT_EN
  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        err_q;

  // Count WAIT cycles; cleared while issuing so each WAIT visit starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // A completion arriving in the terminal-count cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT) && !bus.fc_done && (wait_cnt == TC_LAST);

  // Remember whether the pending response is a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (done_hit) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.resp_err = (resp0 || resp1) && err_q;
`else
  assign timeout_hit  = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // Next-state logic: one command in flight, strictly IDLE -> ISSUE -> WAIT -> RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin pointer, which flips to the other requester after each response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RESP) begin
        rr_ptr <= ~req_id;
      end
    end
  end

  // Latch the accepted command with its bounds ordered low-to-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_id <= 1'b0;
      base_q <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      c1_q   <= '0;
      c2_q   <= '0;
    end else if (accept) begin
      req_id <= grant;
      base_q <= sel_cmd[15:8];
      if (sel_cmd[7:6] > sel_cmd[5:4]) begin
        r1_q <= sel_cmd[5:4];
        r2_q <= sel_cmd[7:6];
      end else begin
        r1_q <= sel_cmd[7:6];
        r2_q <= sel_cmd[5:4];
      end
      if (sel_cmd[3:2] > sel_cmd[1:0]) begin
        c1_q <= sel_cmd[1:0];
        c2_q <= sel_cmd[3:2];
      end else begin
        c1_q <= sel_cmd[3:2];
        c2_q <= sel_cmd[1:0];
      end
    end
  end

  // Capture the flip result, or force zero data when the wait times out.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (done_hit) begin
      data_q <= bus.fc_flipped_out;
    end else if (timeout_hit) begin
      data_q <= '0;
    end
  end

  // Outputs are forced low while reset is asserted, even before the first reset edge.
  assign resp0 = !rst && (state == RESP) && !req_id;
  assign resp1 = !rst && (state == RESP) && req_id;

  assign bus.req0_ready   = !rst && (state == IDLE) && !grant;
  assign bus.req1_ready   = !rst && (state == IDLE) && grant;
  assign bus.resp0_valid  = resp0;
  assign bus.resp1_valid  = resp1;
  assign bus.resp_data    = (resp0 || resp1) ? data_q : 16'h0000;
  assign bus.fc_start     = !rst && (state == ISSUE);
  assign bus.fc_base_addr = rst ? 8'h00 : base_q;
  assign bus.fc_r1        = rst ? 2'b00 : r1_q;
  assign bus.fc_r2        = rst ? 2'b00 : r2_q;
  assign bus.fc_c1        = rst ? 2'b00 : c1_q;
  assign bus.fc_c2        = rst ? 2'b00 : c2_q;
  assign bus.busy         = !rst && (state != IDLE);

endmodule
